// File: rtl/seg_mux_driver.sv
// seg_mux_driver: multiplexed common-anode seven-segment display driver.
// Scans DIGITS positions, one slot of 2^DIV_BITS clocks each, with brightness
// PWM, per-digit blink, leading-zero suppression and per-frame input snapshots.
// Optional feature macro: SEG_HEX_EN (codes 10-15 show A b C d E F; otherwise
// those codes drive all segments off).
//
// Timing notes: pos/segments are registered from the state of the previous
// cycle. frame_tick is delayed through the same one-cycle output stage, so it
// is high together with the first slot-0 output of each new frame.
module seg_mux_driver #(
    parameter int DIGITS     = 8,
    parameter int DIV_BITS   = 6,
    parameter int PWM_BITS   = 4,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digit,
    input  logic [DIGITS-1:0]     en_dot,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_en,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [DIGITS-1:0]     pos,
    output logic [7:0]            segments,
    output logic                  frame_tick
);

    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_BITS-1:0]   pre;
    logic [SLOT_W-1:0]     slot;
    logic [BLINK_LOG2:0]   frame_cnt;
    logic [4*DIGITS-1:0]   snap_digit;
    logic [DIGITS-1:0]     snap_dot;
    logic [DIGITS-1:0]     snap_blink;
    logic                  snap_lz;
    logic                  valid;
    logic                  boundary_d;

    logic                  pre_wrap;
    logic                  boundary;
    logic [DIGITS-1:0]     lz_blank;
    logic                  still_zero;
    logic [3:0]            cur_code;
    logic                  cur_dot;
    logic                  pwm_on;
    logic                  blank;
    logic [7:0]            seg_next;
    logic [DIGITS-1:0]     pos_next;

    // Active-low {a,b,c,d,e,f,g,dp} for one code; hex-disabled codes go dark.
    function automatic logic [7:0] decode(input logic [3:0] code, input logic dot);
        logic [6:0] g;
        logic       dark;
        g    = 7'h7F;
        dark = 1'b0;
        case (code)
            4'd0:  g = 7'b0000001;
            4'd1:  g = 7'b1001111;
            4'd2:  g = 7'b0010010;
            4'd3:  g = 7'b0000110;
            4'd4:  g = 7'b1001100;
            4'd5:  g = 7'b0100100;
            4'd6:  g = 7'b0100000;
            4'd7:  g = 7'b0001111;
            4'd8:  g = 7'b0000000;
            4'd9:  g = 7'b0000100;
`ifdef SEG_HEX_EN
            4'd10: g = 7'b0001000;
            4'd11: g = 7'b1100000;
            4'd12: g = 7'b0110001;
            4'd13: g = 7'b1000010;
            4'd14: g = 7'b0110000;
            default: g = 7'b0111000;
`else
            default: dark = 1'b1;
`endif
        endcase
        return dark ? 8'hFF : {g, ~dot};
    endfunction

    assign pre_wrap = &pre;
    assign boundary = pre_wrap && (slot == SLOT_W'(DIGITS - 1));

    // Prescaler and slot scan; slot steps on every prescaler wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre  <= '0;
            slot <= '0;
        end else begin
            pre <= pre + 1'b1;
            if (pre_wrap) begin
                slot <= (slot == SLOT_W'(DIGITS - 1)) ? '0 : slot + 1'b1;
            end
        end
    end

    // Capture display inputs at each frame boundary so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_digit <= '0;
            snap_dot   <= '0;
            snap_blink <= '0;
            snap_lz    <= 1'b0;
            valid      <= 1'b0;
            frame_cnt  <= '0;
            boundary_d <= 1'b0;
        end else begin
            boundary_d <= boundary;
            if (boundary) begin
                snap_digit <= digit;
                snap_dot   <= en_dot;
                snap_blink <= blink_mask;
                snap_lz    <= lz_en;
                valid      <= 1'b1;
                frame_cnt  <= frame_cnt + 1'b1;
            end
        end
    end

    // Leading-zero mask: blank from the top while code and dot are both zero.
    always_comb begin
        lz_blank   = '0;
        still_zero = snap_lz;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (still_zero && (snap_digit[4*i +: 4] == 4'd0) && !snap_dot[i]) begin
                lz_blank[i] = 1'b1;
            end else begin
                still_zero = 1'b0;
            end
        end
    end

    // Next output for the current slot: blanking, decode and PWM gating.
    always_comb begin
        cur_code = snap_digit[4*int'(slot) +: 4];
        cur_dot  = snap_dot[slot];
        pwm_on   = (pre[DIV_BITS-1 -: PWM_BITS] <= brightness);
        blank    = lz_blank[slot] || (frame_cnt[BLINK_LOG2] && snap_blink[slot]);
        seg_next = 8'hFF;
        pos_next = '1;
        if (valid && !blank) begin
            seg_next = decode(cur_code, cur_dot);
            if (pwm_on) begin
                pos_next = ~(DIGITS'(1) << slot);
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos        <= '1;
            segments   <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            pos        <= pos_next;
            segments   <= seg_next;
            frame_tick <= boundary_d;
        end
    end

endmodule
